// File: rtl/fifo_drain_serializer_if.sv
// Upstream FIFO read port, serial bit handshake and status of fifo_drain_serializer.
// master = the serializer, slave = the FIFO / downstream side.
interface fifo_drain_serializer_if #(
  parameter int FIFO_width  = 32,
  parameter int COUNT_width = 16
);
  logic                   fifoEmpty;
  logic [FIFO_width-1:0]  fifoData;
  logic                   readEnable;
  logic                   serialOut;
  logic                   serialValid;
  logic                   serialReady;
  logic                   frameStart;
  logic                   busy;
  logic [COUNT_width-1:0] wordsSent;

  modport master (
    input  fifoEmpty, fifoData, serialReady,
    output readEnable, serialOut, serialValid, frameStart, busy, wordsSent
  );

  modport slave (
    output fifoEmpty, fifoData, serialReady,
    input  readEnable, serialOut, serialValid, frameStart, busy, wordsSent
  );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Drains words from an upstream FIFO and sends them MSB first over a valid/ready
// serial link, counting completed words.
module fifo_drain_serializer #(
  parameter int FIFO_width  = 32,
  parameter int COUNT_width = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  fifo_drain_serializer_if.master        bus
);

  localparam int                BIT_W    = $clog2(FIFO_width);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FIFO_width - 1);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, SHIFT} state_t;

  state_t                 state, state_next;
  logic [FIFO_width-1:0]  shift_q, shift_next;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
  logic [COUNT_width-1:0] words_q, words_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
      words_q <= '0;
    end else begin
      shift_q <= shift_next;
      bit_cnt <= bit_cnt_next;
      words_q <= words_next;
    end
  end

  // NOTE: every signal written here gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    words_next   = words_q;

    // enable low freezes everything, including a pending REQ or LOAD
    if (enable) begin
      case (state)
        IDLE: begin
          if (!bus.fifoEmpty) state_next = REQ;
        end
        REQ: begin
          state_next = LOAD;
        end
        LOAD: begin
          shift_next   = bus.fifoData;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
        SHIFT: begin
          if (bus.serialReady) begin
            shift_next   = {shift_q[FIFO_width-2:0], 1'b0};
            bit_cnt_next = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              words_next = words_q + 1'b1;
              state_next = bus.fifoEmpty ? IDLE : REQ;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decode registered state; serialOut/frameStart hold while disabled
  // because the state they decode is frozen.
  assign bus.readEnable  = enable && (state == REQ);
  assign bus.serialValid = enable && (state == SHIFT);
  assign bus.serialOut   = shift_q[FIFO_width-1];
  assign bus.frameStart  = (state == SHIFT) && (bit_cnt == '0);
  assign bus.busy        = (state != IDLE);
  assign bus.wordsSent   = words_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench for fifo_drain_serializer: 8-bit words, 2-bit word counter so
// the counter wrap is exercised by the single-word table.
module tb_fifo_drain_serializer;

  localparam int FW = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  fifo_drain_serializer_if #(.FIFO_width(FW), .COUNT_width(CW)) bus ();

  fifo_drain_serializer #(.FIFO_width(FW), .COUNT_width(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model and serial receiver, both evaluated on the falling edge
  logic [FW-1:0] fifo_q[$];
  logic          rx_bit[$];
  logic          rx_frame[$];
  int            rx_cyc[$];
  int            cyc = 0;
  int            reads, shift_cycles, first_re, first_valid;

  always @(negedge clk) begin
    cyc++;
    if (bus.readEnable) begin
      reads++;
      if (first_re < 0) first_re = cyc;
      check("read_while_empty", 32'(bus.fifoEmpty), 32'd0);
      if (fifo_q.size() > 0) bus.fifoData = fifo_q.pop_front();
      bus.fifoEmpty = (fifo_q.size() == 0);
    end
    if (bus.serialValid) begin
      shift_cycles++;
      if (first_valid < 0) first_valid = cyc;
      if (bus.serialReady) begin
        rx_bit.push_back(bus.serialOut);
        rx_frame.push_back(bus.frameStart);
        rx_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_mon();
    rx_bit.delete();
    rx_frame.delete();
    rx_cyc.delete();
    reads        = 0;
    shift_cycles = 0;
    first_re     = -1;
    first_valid  = -1;
  endtask

  task automatic push_word(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    bus.fifoEmpty = 1'b0;
  endtask

  function automatic logic [15:0] pack(input int n, input bit frames);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n && i < rx_bit.size(); i++)
      v = {v[14:0], frames ? rx_frame[i] : rx_bit[i]};
    return v;
  endfunction

  task automatic wait_done(input int nbits, input bit stall);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (stall) bus.serialReady = ~bus.serialReady;
      if (rx_bit.size() >= nbits && !bus.busy) done = 1'b1;
    end
    check("word_done", 32'(done), 32'd1);
    bus.serialReady = 1'b1;
  endtask

  task automatic wait_bits(input int nbits);
    for (int i = 0; i < 100 && rx_bit.size() < nbits; i++) begin
      @(posedge clk);
      #1;
    end
    check("bits_reached", 32'(rx_bit.size() >= nbits), 32'd1);
  endtask

  typedef struct {
    logic [FW-1:0] data;
    bit            stall;
    logic [FW-1:0] exp_bits;
    int            exp_cycles;
    logic [CW-1:0] exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8'b1010_0101,  8, 2'd1};
    vecs[1] = '{8'hC3, 1'b1, 8'b1100_0011, 16, 2'd2};
    vecs[2] = '{8'h5A, 1'b0, 8'b0101_1010,  8, 2'd3};
    vecs[3] = '{8'h80, 1'b1, 8'b1000_0000, 16, 2'd0};
    vecs[4] = '{8'h01, 1'b0, 8'b0000_0001,  8, 2'd1};

    reset           = 1'b1;
    enable          = 1'b1;
    bus.fifoEmpty   = 1'b1;
    bus.fifoData    = '0;
    bus.serialReady = 1'b1;
    clear_mon();

    repeat (3) @(posedge clk);
    #1;
    check("rst_readEnable",  32'(bus.readEnable),  32'd0);
    check("rst_serialOut",   32'(bus.serialOut),   32'd0);
    check("rst_serialValid", 32'(bus.serialValid), 32'd0);
    check("rst_frameStart",  32'(bus.frameStart),  32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_wordsSent",   32'(bus.wordsSent),   32'd0);
    reset = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("idle_when_empty", 32'(bus.busy), 32'd0);

    // single words; wordsSent walks 1,2,3,0,1
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      clear_mon();
      push_word(vecs[k].data);
      bus.serialReady = 1'b1;
      wait_done(FW, vecs[k].stall);
      check($sformatf("v%0d_bits", k),    32'(pack(FW, 1'b0)), 32'(vecs[k].exp_bits));
      check($sformatf("v%0d_frame", k),   32'(pack(FW, 1'b1)), 32'h80);
      check($sformatf("v%0d_shift", k),   32'(shift_cycles),   32'(vecs[k].exp_cycles));
      check($sformatf("v%0d_latency", k), 32'(first_valid - first_re), 32'd2);
      check($sformatf("v%0d_reads", k),   32'(reads),          32'd1);
      check($sformatf("v%0d_words", k),   32'(bus.wordsSent),  32'(vecs[k].exp_words));
    end

    // back-to-back 0xFF, 0x00: two-cycle gap for REQ+LOAD
    @(posedge clk);
    #1;
    clear_mon();
    push_word(8'hFF);
    push_word(8'h00);
    wait_done(2 * FW, 1'b0);
    check("b2b_bits",  32'(pack(16, 1'b0)), 32'hFF00);
    check("b2b_frame", 32'(pack(16, 1'b1)), 32'h8080);
    check("b2b_gap",   32'((rx_cyc.size() >= 9) ? rx_cyc[8] - rx_cyc[7] - 1 : -1), 32'd2);
    check("b2b_shift", 32'(shift_cycles),   32'd16);
    check("b2b_reads", 32'(reads),          32'd2);
    check("b2b_words", 32'(bus.wordsSent),  32'd3);

    // async reset between edges while bit 4 of 0x9E (a 1) is on the line
    @(posedge clk);
    #1;
    clear_mon();
    push_word(8'h9E);
    wait_bits(4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",        32'(bus.busy),        32'd0);
    check("arst_serialValid", 32'(bus.serialValid), 32'd0);
    check("arst_serialOut",   32'(bus.serialOut),   32'd0);
    check("arst_frameStart",  32'(bus.frameStart),  32'd0);
    check("arst_wordsSent",   32'(bus.wordsSent),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    push_word(8'h3C);
    wait_done(FW, 1'b0);
    check("post_rst_bits",  32'(pack(FW, 1'b0)), 32'h3C);
    check("post_rst_frame", 32'(pack(FW, 1'b1)), 32'h80);
    check("post_rst_words", 32'(bus.wordsSent),  32'd1);

    // enable dropped for 3 cycles in REQ, then for 3 cycles with bit 3 presented
    @(posedge clk);
    #1;
    clear_mon();
    push_word(8'hB4);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    check("en_req_readEnable", 32'(bus.readEnable), 32'd0);
    check("en_req_busy",       32'(bus.busy),       32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_bits(3);
    enable = 1'b0;
    @(negedge clk);
    check("en_shift_valid",     32'(bus.serialValid), 32'd0);
    check("en_shift_serialOut", 32'(bus.serialOut),   32'd1);
    check("en_shift_frame",     32'(bus.frameStart),  32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_done(FW, 1'b0);
    check("en_bits",   32'(pack(FW, 1'b0)), 32'hB4);
    check("en_frame",  32'(pack(FW, 1'b1)), 32'h80);
    check("en_reads",  32'(reads),          32'd1);
    check("en_tail",   32'((rx_cyc.size() >= 8) ? rx_cyc[7] - rx_cyc[3] : -1), 32'd4);
    check("en_words",  32'(bus.wordsSent),  32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
